// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D responder and its SPI frame engine.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME1,
        GAP,
        FRAME2
    } a2dState_e;

    localparam int FRAME_BITS = 16;
    localparam int RES_W = 12;
    localparam logic [10:0] CMD_PAD = 11'h000;

    // Front porch, 32 SCLK half periods and back porch.
    localparam int HALF_PERIODS = 2 * FRAME_BITS + 2;

    function automatic logic [FRAME_BITS-1:0] mkCmd(input logic [2:0] chnnl);
        return {2'b00, chnnl, CMD_PAD};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Single 16-bit SPI frame engine: porch, 16 SCLK periods and porch, with SCLK idling high.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrt,
    input  logic [FRAME_BITS-1:0] cmd,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int PHW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PHW-1:0] PH_LAST = PHW'(HALF - 1);
    localparam logic [PHW-1:0] PH_ONE = PHW'(1);
    localparam logic [5:0] HC_LAST = 6'(HALF_PERIODS - 1);

    logic                  busy_q, busy_d;
    logic [PHW-1:0]        ph_q, ph_d;
    logic [5:0]            hc_q, hc_d;
    logic                  sclk_q, sclk_d;
    logic                  ssn_q, ssn_d;
    logic                  done_q, done_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [5:0]            hcNext;
    logic                  lowHalf;

    // Odd half periods (except the back porch) are SCLK-low; even ones after the first are SCLK-high.
    always_comb begin
        busy_d  = busy_q;
        ph_d    = ph_q;
        hc_d    = hc_q;
        sclk_d  = sclk_q;
        ssn_d   = ssn_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        hcNext  = hc_q + 6'd1;
        lowHalf = hcNext[0] && (hcNext != HC_LAST);

        if (!busy_q) begin
            if (wrt) begin
                busy_d = 1'b1;
                ssn_d  = 1'b0;
                ph_d   = '0;
                hc_d   = '0;
                tx_d   = cmd;
                rx_d   = '0;
            end
        end else if (ph_q != PH_LAST) begin
            ph_d = ph_q + PH_ONE;
        end else if (hc_q == HC_LAST) begin
            busy_d = 1'b0;
            ssn_d  = 1'b1;
            sclk_d = 1'b1;
            done_d = 1'b1;
            tx_d   = '0;
            ph_d   = '0;
            hc_d   = '0;
        end else begin
            ph_d   = '0;
            hc_d   = hcNext;
            sclk_d = ~lowHalf;
            if (lowHalf && (hcNext != 6'd1)) begin
                tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (!hcNext[0]) begin
                rx_d = {rx_q[FRAME_BITS-2:0], MISO};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            ph_q   <= '0;
            hc_q   <= '0;
            sclk_q <= 1'b1;
            ssn_q  <= 1'b1;
            done_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            busy_q <= busy_d;
            ph_q   <= ph_d;
            hc_q   <= hc_d;
            sclk_q <= sclk_d;
            ssn_q  <= ssn_d;
            done_q <= done_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    assign SS_n    = ssn_q;
    assign SCLK    = sclk_q;
    assign MOSI    = ~ssn_q & tx_q[FRAME_BITS-1];
    assign done    = done_q;
    assign rd_data = rx_q;

endmodule

// File: rtl/a2d_intf.sv
// A2D responder: on strt_cnv runs a command frame then a readback frame and presents the 12-bit result.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_cnv,
    input  logic [2:0]       chnnl,
    output logic             cnv_cmplt,
    output logic [RES_W-1:0] res,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int GW = $clog2(SCLK_DIV);
    localparam logic [GW-1:0] GAP_LAST = GW'(SCLK_DIV / 2 - 2);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);

    a2dState_e             state_q, state_d;
    logic [FRAME_BITS-1:0] cmd_q, cmd_d;
    logic                  cnvCmplt_q, cnvCmplt_d;
    logic [RES_W-1:0]      res_q, res_d;
    logic [GW-1:0]         gapCnt_q, gapCnt_d;
    logic                  wrt;
    logic [FRAME_BITS-1:0] spiCmd;
    logic                  spiDone;
    logic [FRAME_BITS-1:0] spiRd;
    logic                  unusedRdHi;

    // The engine's done arrives one clk after SS_n rises, so GAP spends one clk fewer than the SS_n-high gap.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnvCmplt_d = cnvCmplt_q;
        res_d      = res_q;
        gapCnt_d   = '0;
        wrt        = 1'b0;
        spiCmd     = cmd_q;

        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    spiCmd     = mkCmd(chnnl);
                    cmd_d      = spiCmd;
                    wrt        = 1'b1;
                    cnvCmplt_d = 1'b0;
                    state_d    = FRAME1;
                end
            end
            FRAME1: begin
                if (spiDone) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gapCnt_d = gapCnt_q + GAP_ONE;
                if (gapCnt_q == GAP_LAST) begin
                    gapCnt_d = '0;
                    wrt      = 1'b1;
                    state_d  = FRAME2;
                end
            end
            FRAME2: begin
                if (spiDone) begin
                    res_d      = spiRd[RES_W-1:0];
                    cnvCmplt_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            cnvCmplt_q <= 1'b0;
            res_q      <= '0;
            gapCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnvCmplt_q <= cnvCmplt_d;
            res_q      <= res_d;
            gapCnt_q   <= gapCnt_d;
        end
    end

    spi_mstr16 #(
        .SCLK_DIV(SCLK_DIV)
    ) u_spi (
        .clk    (clk),
        .rst    (rst),
        .wrt    (wrt),
        .cmd    (spiCmd),
        .done   (spiDone),
        .rd_data(spiRd),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    assign unusedRdHi = ^spiRd[FRAME_BITS-1:RES_W];
    assign cnv_cmplt  = cnvCmplt_q;
    assign res        = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC that answers 16'hC3C3 in frame 1 and a chosen word in frame 2.
module tb_a2d_intf;

    localparam int D = 32;
    localparam int LAT = 34 * D + D / 2 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        MISO;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    int checks = 0;
    int errors = 0;
    int lat;

    int          framesSeen = 0;
    int          frameBase = 0;
    int          fallCnt = 0;
    int          sclkToggles = 0;
    int          cmpltRises = 0;
    int          resChanges = 0;
    int          baseFalls, baseFrames, baseRises, baseRes, baseToggles;
    logic [15:0] adcWord = 16'h0000;
    logic [15:0] adcShift = 16'h0000;
    logic [15:0] mosiShift = 16'h0000;
    logic [15:0] mosiFrame [2];
    bit          firstFall = 1'b0;

    a2d_intf #(
        .SCLK_DIV(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    // ADC model: data changes on SCLK falls (not the first of a frame), master samples on rises.
    assign MISO = adcShift[15];

    always @(negedge SS_n) begin
        framesSeen++;
        firstFall = 1'b1;
        mosiShift = 16'h0000;
        adcShift  = (framesSeen - frameBase == 2) ? adcWord : 16'hC3C3;
    end

    always @(posedge SS_n) begin
        if ((framesSeen - frameBase >= 1) && (framesSeen - frameBase <= 2))
            mosiFrame[framesSeen - frameBase - 1] = mosiShift;
    end

    always @(negedge SCLK) begin
        fallCnt++;
        if (!SS_n) begin
            if (firstFall) firstFall = 1'b0;
            else adcShift = {adcShift[14:0], 1'b0};
        end
    end

    always @(posedge SCLK) begin
        if (!SS_n) mosiShift = {mosiShift[14:0], MOSI};
    end

    always @(SCLK) sclkToggles++;
    always @(posedge cnv_cmplt) cmpltRises++;
    always @(res) resChanges++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the edge that accepted strt_cnv.
    task automatic applyStimulus(input logic [2:0] ch, input logic [15:0] word);
        adcWord    = word;
        frameBase  = framesSeen;
        baseFalls  = fallCnt;
        baseFrames = framesSeen;
        baseRises  = cmpltRises;
        baseRes    = resChanges;
        strt_cnv   = 1'b1;
        chnnl      = ch;
        @(posedge clk);
        @(negedge clk);
        strt_cnv = 1'b0;
    endtask

    task automatic waitForCompletion(input int pulseA, input int pulseB, output int latency);
        latency = -1;
        for (int cnt = 1; cnt <= 3000; cnt++) begin
            @(posedge clk);
            @(negedge clk);
            if (cnv_cmplt) begin
                latency = cnt;
                break;
            end
            strt_cnv = (cnt == pulseA) || (cnt == pulseB);
            if (strt_cnv) chnnl = 3'd4;
        end
        strt_cnv = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset SS_n", 32'(SS_n), 32'd1);
        checkOutput("reset SCLK", 32'(SCLK), 32'd1);
        checkOutput("reset MOSI", 32'(MOSI), 32'd0);
        checkOutput("reset cnv_cmplt", 32'(cnv_cmplt), 32'd0);
        checkOutput("reset res", 32'(res), 32'h000);
        baseToggles = sclkToggles;
        repeat (200) @(negedge clk);
        checkOutput("idle SCLK toggles", 32'(sclkToggles - baseToggles), 32'd0);

        $display("[TB] channel 1, ADC word 0ABC");
        applyStimulus(3'd1, 16'h0ABC);
        waitForCompletion(0, 0, lat);
        checkOutput("ch1 latency", 32'(lat), 32'(LAT));
        checkOutput("ch1 res", 32'(res), 32'hABC);
        checkOutput("ch1 frame1 MOSI", 32'(mosiFrame[0]), 32'h0800);
        checkOutput("ch1 frame2 MOSI", 32'(mosiFrame[1]), 32'h0800);
        checkOutput("ch1 SCLK falls", 32'(fallCnt - baseFalls), 32'd32);
        checkOutput("ch1 SS_n pulses", 32'(framesSeen - baseFrames), 32'd2);
        checkOutput("ch1 res changes", 32'(resChanges - baseRes), 32'd1);
        repeat (5) @(negedge clk);

        $display("[TB] channel 7, ADC word FFFF");
        applyStimulus(3'd7, 16'hFFFF);
        waitForCompletion(0, 0, lat);
        checkOutput("ch7 latency", 32'(lat), 32'(LAT));
        checkOutput("ch7 res", 32'(res), 32'hFFF);
        checkOutput("ch7 frame1 MOSI", 32'(mosiFrame[0]), 32'h3800);
        checkOutput("ch7 frame2 MOSI", 32'(mosiFrame[1]), 32'h3800);
        repeat (5) @(negedge clk);

        $display("[TB] channel 2 with ignored requests at clks 100 and 700");
        applyStimulus(3'd2, 16'h0321);
        waitForCompletion(100, 700, lat);
        checkOutput("ch2 latency", 32'(lat), 32'(LAT));
        checkOutput("ch2 frame1 MOSI", 32'(mosiFrame[0]), 32'h1000);
        checkOutput("ch2 frame2 MOSI", 32'(mosiFrame[1]), 32'h1000);
        checkOutput("ch2 res", 32'(res), 32'h321);
        repeat (50) @(negedge clk);
        checkOutput("ch2 completions", 32'(cmpltRises - baseRises), 32'd1);
        checkOutput("ch2 SS_n pulses", 32'(framesSeen - baseFrames), 32'd2);

        $display("[TB] reset inside frame 1");
        applyStimulus(3'd6, 16'h0666);
        repeat (299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort SS_n", 32'(SS_n), 32'd1);
        checkOutput("abort SCLK", 32'(SCLK), 32'd1);
        checkOutput("abort MOSI", 32'(MOSI), 32'd0);
        checkOutput("abort cnv_cmplt", 32'(cnv_cmplt), 32'd0);
        checkOutput("abort res", 32'(res), 32'h000);
        baseToggles = sclkToggles;
        repeat (100) @(negedge clk);
        checkOutput("abort idle toggles", 32'(sclkToggles - baseToggles), 32'd0);

        applyStimulus(3'd0, 16'h0F0F);
        waitForCompletion(0, 0, lat);
        checkOutput("ch0 latency", 32'(lat), 32'(LAT));
        checkOutput("ch0 res", 32'(res), 32'hF0F);
        checkOutput("ch0 frame2 MOSI", 32'(mosiFrame[1]), 32'h0000);

        $display("[TB] back-to-back request on channel 5");
        applyStimulus(3'd5, 16'h5A5A);
        checkOutput("b2b cnv_cmplt cleared", 32'(cnv_cmplt), 32'd0);
        checkOutput("b2b res held", 32'(res), 32'hF0F);
        waitForCompletion(0, 0, lat);
        checkOutput("b2b latency", 32'(lat), 32'(LAT));
        checkOutput("b2b res", 32'(res), 32'hA5A);
        checkOutput("b2b frame2 MOSI", 32'(mosiFrame[1]), 32'h2800);
        checkOutput("b2b res changes", 32'(resChanges - baseRes), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
